// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: timing derivation, color byte placement and
// receiver state encoding, used by both the transmitter and the receiver.
package ws2812_pkg;

    // Byte positions inside the 32-bit color word; [31:24] is always zero.
    localparam int COLOR_G_LSB = 0;
    localparam int COLOR_R_LSB = 8;
    localparam int COLOR_B_LSB = 16;

    localparam logic [1:0] ST_WAIT_GAP = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    function automatic int cycle_count(input int clock_frq);
        return clock_frq / 800_000;
    endfunction

    function automatic int bit_thresh(input int cycles);
        return cycles / 2;
    endfunction

    function automatic int high_max(input int cycles);
        return 2 * cycles;
    endfunction

    function automatic int gap_count(input int clock_frq, input int gap_us);
        return gap_us * (clock_frq / 1_000_000);
    endfunction

    function automatic logic [31:0] grb_to_color(input logic [23:0] grb);
        logic [31:0] color;
        color = 32'h0000_0000;
        color[COLOR_G_LSB +: 8] = grb[23:16];
        color[COLOR_R_LSB +: 8] = grb[15:8];
        color[COLOR_B_LSB +: 8] = grb[7:0];
        return color;
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-output bundle of the WS2812 receiver; master is the decoder,
// slave is whatever consumes the decoded words and frame events.
interface ws2812_rx_if #(
    parameter int ADDR_W = 3
) ();

    logic [31:0]       color_rgb;
    logic              color_valid;
    logic [ADDR_W-1:0] current_ledN;
    logic              frame_done;
    logic [ADDR_W-1:0] led_count;
    logic              overflow;
    logic              bit_error;

    modport master (
        output color_rgb,
        output color_valid,
        output current_ledN,
        output frame_done,
        output led_count,
        output overflow,
        output bit_error
    );

    modport slave (
        input color_rgb,
        input color_valid,
        input current_ledN,
        input frame_done,
        input led_count,
        input overflow,
        input bit_error
    );

endinterface

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus a registered
// level and rise/fall pulses that stay aligned with that level.
module ws2812_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_r;
    logic       level_r;
    logic       rise_r;
    logic       fall_r;

    // Synchronizer chain, edge detect against the previous synchronized level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r  <= 2'b00;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], din};
            level_r <= sync_r[1];
            rise_r  <= sync_r[1] & ~level_r;
            fall_r  <= ~sync_r[1] & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receive decoder: classifies bits by high-pulse width, assembles
// 24-bit GRB words per LED and reports frame end, overflow and protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int LEDS_NUM     = 7,
    parameter int CLOCK_FRQ    = 50_000_000,
    parameter int RESET_GAP_US = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ws_data_in,
    ws2812_rx_if.master rx
);

    localparam int CLOCK_CYCLE_COUNT = cycle_count(CLOCK_FRQ);
    localparam int BIT_THRESH        = bit_thresh(CLOCK_CYCLE_COUNT);
    localparam int HIGH_MAX          = high_max(CLOCK_CYCLE_COUNT);
    localparam int RESET_GAP_COUNT   = gap_count(CLOCK_FRQ, RESET_GAP_US);
    localparam int CNT_WIDTH         = $clog2(RESET_GAP_COUNT + 1);
    localparam int LED_ADDR_WIDTH    = $clog2(LEDS_NUM + 1);

    localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_SAT   = CNT_WIDTH'(RESET_GAP_COUNT);
    localparam logic [CNT_WIDTH-1:0]      GAP_LAST  = CNT_WIDTH'(RESET_GAP_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0]      HIGH_LAST = CNT_WIDTH'(HIGH_MAX - 1);
    localparam logic [CNT_WIDTH-1:0]      THRESH    = CNT_WIDTH'(BIT_THRESH);
    localparam logic [LED_ADDR_WIDTH-1:0] LED_LIMIT = LED_ADDR_WIDTH'(LEDS_NUM);
    localparam logic [LED_ADDR_WIDTH-1:0] LED_ONE   = LED_ADDR_WIDTH'(1);

    logic line_s;
    logic rise_s;
    logic fall_s;
    logic bit_s;
    logic [23:0] word_s;

    logic [1:0]                state_r;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [22:0]               shift_r;
    logic [4:0]                bit_cnt_r;
    logic [LED_ADDR_WIDTH-1:0] led_cnt_r;
    logic [31:0]               color_rgb_r;
    logic                      color_valid_r;
    logic [LED_ADDR_WIDTH-1:0] current_led_r;
    logic                      frame_done_r;
    logic [LED_ADDR_WIDTH-1:0] led_count_r;
    logic                      overflow_r;
    logic                      bit_error_r;

    ws2812_sync_edge u_sync_edge (
        .clock (clock),
        .reset (reset),
        .din   (ws_data_in),
        .level (line_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // At a fall cnt_r holds the number of high cycles just ended.
    assign bit_s  = (cnt_r >= THRESH);
    assign word_s = {shift_r, bit_s};

    // Width counter: the edge cycle is the first cycle of the new level; saturates at the gap length.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (rise_s || fall_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_SAT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Frame/bit state machine with registered outputs and single-cycle strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_WAIT_GAP;
            shift_r       <= 23'h0;
            bit_cnt_r     <= 5'd0;
            led_cnt_r     <= {LED_ADDR_WIDTH{1'b0}};
            color_rgb_r   <= 32'h0000_0000;
            color_valid_r <= 1'b0;
            current_led_r <= {LED_ADDR_WIDTH{1'b0}};
            frame_done_r  <= 1'b0;
            led_count_r   <= {LED_ADDR_WIDTH{1'b0}};
            overflow_r    <= 1'b0;
            bit_error_r   <= 1'b0;
        end else begin
            color_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            overflow_r    <= 1'b0;
            bit_error_r   <= 1'b0;
            case (state_r)
                ST_WAIT_GAP: begin
                    if (!line_s && (cnt_r >= GAP_LAST)) begin
                        state_r   <= ST_IDLE;
                        shift_r   <= 23'h0;
                        bit_cnt_r <= 5'd0;
                        led_cnt_r <= {LED_ADDR_WIDTH{1'b0}};
                    end
                end
                ST_IDLE: begin
                    if (rise_s) begin
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        shift_r <= word_s[22:0];
                        state_r <= ST_LOW;
                        if (bit_cnt_r == 5'd23) begin
                            bit_cnt_r <= 5'd0;
                            if (led_cnt_r < LED_LIMIT) begin
                                color_valid_r <= 1'b1;
                                color_rgb_r   <= grb_to_color(word_s);
                                current_led_r <= led_cnt_r;
                                led_cnt_r     <= led_cnt_r + LED_ONE;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end else if (cnt_r >= HIGH_LAST) begin
                        // Stuck-high line: drop the frame and resynchronise on a full gap.
                        bit_error_r <= 1'b1;
                        shift_r     <= 23'h0;
                        bit_cnt_r   <= 5'd0;
                        led_cnt_r   <= {LED_ADDR_WIDTH{1'b0}};
                        state_r     <= ST_WAIT_GAP;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        state_r <= ST_HIGH;
                    end else if (cnt_r >= GAP_LAST) begin
                        frame_done_r <= 1'b1;
                        led_count_r  <= led_cnt_r;
                        bit_error_r  <= (bit_cnt_r != 5'd0);
                        shift_r      <= 23'h0;
                        bit_cnt_r    <= 5'd0;
                        led_cnt_r    <= {LED_ADDR_WIDTH{1'b0}};
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_WAIT_GAP;
                end
            endcase
        end
    end

    assign rx.color_rgb    = color_rgb_r;
    assign rx.color_valid  = color_valid_r;
    assign rx.current_ledN = current_led_r;
    assign rx.frame_done   = frame_done_r;
    assign rx.led_count    = led_count_r;
    assign rx.overflow     = overflow_r;
    assign rx.bit_error    = bit_error_r;

endmodule
